// File: rtl/sop_pkg.sv
// sop_pkg
//   Shared definitions for the sum-of-products datapath: default operand
//   widths, the accumulator FSM state encoding, and the result-width
//   derivation that the multiplier top level reuses.
package sop_pkg;

  // Default operand width feeding the upstream multiplier, and the default
  // number of products summed per result.
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_NUM_TERMS  = 4;

  // Accumulator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Result width large enough that num_terms products of prod_width bits
  // can never wrap.
  function automatic int sum_width(input int prod_width, input int num_terms);
    return prod_width + $clog2(num_terms);
  endfunction

endpackage

// File: rtl/sop_accumulator_if.sv
// sop_accumulator_if
//   Product-in / sum-out handshake bundle for the accumulation stage.
//   Ports (as seen from the accumulator, modport slave):
//     clr        in   synchronous abort of the current accumulation
//     m_in       in   product from the multiplier
//     in_valid   in   m_in is valid
//     in_ready   out  accumulator can take m_in this cycle
//     sum_out    out  completed sum, registered
//     out_valid  out  sum_out holds a completed result
//     out_ready  in   consumer accepts sum_out
//     term_cnt   out  terms accepted in the current frame
//   The master modport is the environment side (multiplier + consumer).
interface sop_accumulator_if #(
  parameter int PROD_WIDTH = 8,
  parameter int SUM_WIDTH  = 10,
  parameter int CNT_WIDTH  = 3
);

  logic                  clr;
  logic [PROD_WIDTH-1:0] m_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [SUM_WIDTH-1:0]  sum_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  term_cnt;

  modport master (
    output clr,
    output m_in,
    output in_valid,
    input  in_ready,
    input  sum_out,
    input  out_valid,
    output out_ready,
    input  term_cnt
  );

  modport slave (
    input  clr,
    input  m_in,
    input  in_valid,
    output in_ready,
    output sum_out,
    output out_valid,
    input  out_ready,
    output term_cnt
  );

endinterface

// File: rtl/sop_term_counter.sv
// sop_term_counter
//   Counts products accepted in the current frame.
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   asynchronous, active-high reset
//     clr    in   return count to 0 (highest priority after rst)
//     load   in   start a new frame: count becomes 1
//     inc    in   one more term accepted
//     cnt    out  current count
//     last   out  count is NUM_TERMS-1, so the next accepted term ends the frame
module sop_term_counter #(
  parameter int NUM_TERMS = 4,
  parameter int CNT_WIDTH = $clog2(NUM_TERMS+1)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 last
);

  // The frame-ending transfer clears rather than increments, so the count
  // never actually sits at NUM_TERMS; terminal count is flagged one early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_WIDTH'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign last = (cnt == CNT_WIDTH'(NUM_TERMS - 1));

endmodule

// File: rtl/sop_accumulator.sv
// sop_accumulator
//   Sums exactly NUM_TERMS unsigned products arriving over a valid/ready
//   handshake and presents each result on a registered valid/ready output.
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous, active-high reset
//     bus   sop_accumulator_if.slave (clr, m_in/in_valid/in_ready,
//           sum_out/out_valid/out_ready, term_cnt)
module sop_accumulator
  import sop_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PROD_WIDTH = 2*DATA_WIDTH,
  parameter int NUM_TERMS  = DEF_NUM_TERMS,
  parameter int CNT_WIDTH  = $clog2(NUM_TERMS+1),
  parameter int SUM_WIDTH  = sum_width(PROD_WIDTH, NUM_TERMS)
)(
  input logic              clk,
  input logic              rst,
  sop_accumulator_if.slave bus
);

  state_t                state;
  logic [SUM_WIDTH-1:0]  acc;
  logic [SUM_WIDTH-1:0]  sum_reg;
  logic                  out_valid_reg;
  logic [SUM_WIDTH-1:0]  prod_ext;
  logic [SUM_WIDTH-1:0]  next_sum;
  logic                  in_ready_int;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  cnt_clr;
  logic                  cnt_load;
  logic                  cnt_inc;
  logic                  cnt_last;
  logic [CNT_WIDTH-1:0]  cnt;

  assign prod_ext = SUM_WIDTH'(bus.m_in);
  assign next_sum = acc + prod_ext;

  // In HOLD the input side follows out_ready directly, so a product can be
  // taken on the very edge the finished sum leaves; that is what lets frames
  // run back to back. Nothing is accepted while reset is asserted.
  always_comb begin
    in_ready_int = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:  in_ready_int = 1'b1;
        ST_ACCUM: in_ready_int = 1'b1;
        ST_HOLD:  in_ready_int = bus.out_ready;
        default:  in_ready_int = 1'b0;
      endcase
    end
  end

  assign in_xfer  = bus.in_valid && in_ready_int;
  assign out_xfer = out_valid_reg && bus.out_ready;

  // Counter control. A product accepted outside ACCUM always opens a new
  // frame (load to 1); inside ACCUM it either counts up or, when it is the
  // final term, sends the count back to zero. clr outranks everything.
  assign cnt_clr  = bus.clr || (in_xfer && (state == ST_ACCUM) && cnt_last);
  assign cnt_load = in_xfer && (state != ST_ACCUM);
  assign cnt_inc  = in_xfer && (state == ST_ACCUM);

  sop_term_counter #(
    .NUM_TERMS (NUM_TERMS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_term_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Frame FSM, accumulator and output register. The first product of a frame
  // is loaded rather than added, so the accumulator never needs clearing
  // between frames. clr abandons everything except the last published sum,
  // which stays visible for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      acc           <= '0;
      sum_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (bus.clr) begin
      state         <= ST_IDLE;
      acc           <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            acc   <= prod_ext;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_xfer) begin
            acc <= next_sum;
            if (cnt_last) begin
              sum_reg       <= next_sum;
              out_valid_reg <= 1'b1;
              state         <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_xfer) begin
            out_valid_reg <= 1'b0;
            if (in_xfer) begin
              acc   <= prod_ext;
              state <= ST_ACCUM;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.sum_out   = sum_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.term_cnt  = cnt;

endmodule

// File: tb/tb_sop_accumulator.sv
// tb_sop_accumulator
//   Directed bench for sop_accumulator at default widths (8-bit products,
//   10-bit sums, 4 terms per frame). Expected values are hand computed.
module tb_sop_accumulator;

  localparam int PROD_WIDTH = 8;
  localparam int SUM_WIDTH  = 10;
  localparam int CNT_WIDTH  = 3;

  logic clk;
  logic rst;

  int compare_count;
  int mismatch_count;

  sop_accumulator_if #(
    .PROD_WIDTH (PROD_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) bus ();

  sop_accumulator #(
    .DATA_WIDTH (4),
    .PROD_WIDTH (PROD_WIDTH),
    .NUM_TERMS  (4),
    .CNT_WIDTH  (CNT_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [PROD_WIDTH-1:0] d,
                       input logic ordy, input logic c);
    bus.in_valid  = v;
    bus.m_in      = d;
    bus.out_ready = ordy;
    bus.clr       = c;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [PROD_WIDTH-1:0] d,
                               input logic ordy, input logic c);
    drive(v, d, ordy, c);
    stepClock();
  endtask

  initial begin
    logic [PROD_WIDTH-1:0] gap_data [7];
    logic                  gap_valid [7];
    logic [CNT_WIDTH-1:0]  gap_cnt [7];

    compare_count  = 0;
    mismatch_count = 0;
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b1, 1'b0);

    // Reset state.
    #2;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_sum_out", 32'(bus.sum_out), 0);
    checkOutput("rst_term_cnt", 32'(bus.term_cnt), 0);
    stepClock();
    rst = 1'b0;
    stepClock();
    checkOutput("idle_in_ready", 32'(bus.in_ready), 1);

    // Reset pulse while idle, released away from the clock edge.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    stepClock();

    // Basic frame: 4 x 225 = 900.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'd225, 1'b1, 1'b0);
      if (i < 3) checkOutput($sformatf("basic_cnt%0d", i), 32'(bus.term_cnt), 32'(i + 1));
    end
    checkOutput("basic_out_valid", 32'(bus.out_valid), 1);
    checkOutput("basic_sum", 32'(bus.sum_out), 900);
    checkOutput("basic_cnt_wrap", 32'(bus.term_cnt), 0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("basic_valid_one_cycle", 32'(bus.out_valid), 0);

    // Gapped input: 3, -, -, 10, -, 0, 7 = 20.
    gap_data  = '{8'd3, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd7};
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_cnt   = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 7; i++) begin
      // Products on idle cycles are junk and must not be summed.
      applyStimulus(gap_valid[i], gap_valid[i] ? gap_data[i] : 8'd77, 1'b1, 1'b0);
      checkOutput($sformatf("gap_cnt%0d", i), 32'(bus.term_cnt), 32'(gap_cnt[i]));
    end
    checkOutput("gap_out_valid", 32'(bus.out_valid), 1);
    checkOutput("gap_sum", 32'(bus.sum_out), 20);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // Backpressure: 4 x 14 = 56 held while the consumer stalls.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd14, 1'b0, 1'b0);
    checkOutput("bp_out_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
      checkOutput($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 0);
      checkOutput($sformatf("bp_hold_sum%0d", i), 32'(bus.sum_out), 56);
      checkOutput($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 1);
    end
    drive(1'b1, 8'd1, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 1);
    stepClock();
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 0);
    checkOutput("bp_no_bubble_cnt", 32'(bus.term_cnt), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
    checkOutput("bp_second_valid", 32'(bus.out_valid), 1);
    checkOutput("bp_second_sum", 32'(bus.sum_out), 4);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // clr mid-frame: 50, 60, then clr alongside a valid 99.
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd60, 1'b1, 1'b0);
    checkOutput("clr_pre_cnt", 32'(bus.term_cnt), 2);
    applyStimulus(1'b1, 8'd99, 1'b1, 1'b1);
    checkOutput("clr_cnt", 32'(bus.term_cnt), 0);
    checkOutput("clr_out_valid", 32'(bus.out_valid), 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    checkOutput("clr_next_valid", 32'(bus.out_valid), 1);
    checkOutput("clr_next_sum", 32'(bus.sum_out), 10);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // clr while holding 900.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd225, 1'b0, 1'b0);
    checkOutput("hclr_pre_valid", 32'(bus.out_valid), 1);
    checkOutput("hclr_pre_sum", 32'(bus.sum_out), 900);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("hclr_out_valid", 32'(bus.out_valid), 0);
    checkOutput("hclr_sum_kept", 32'(bus.sum_out), 900);
    // With out_ready low, in_ready=1 only if the FSM really is in IDLE.
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    checkOutput("hclr_idle_in_ready", 32'(bus.in_ready), 1);
    stepClock();

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b0);
    checkOutput("arst_pre_cnt", 32'(bus.term_cnt), 2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_cnt", 32'(bus.term_cnt), 0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("arst_sum", 32'(bus.sum_out), 0);
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
    checkOutput("arst_fresh_cnt", 32'(bus.term_cnt), 1);
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
    checkOutput("arst_fresh_valid", 32'(bus.out_valid), 1);
    checkOutput("arst_fresh_sum", 32'(bus.sum_out), 20);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("final_idle_valid", 32'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
